// File: rtl/amba_lite_master_if.sv
// Command/response and AXI-Lite-style bus signals of amba_lite_master, grouped.
// The master modport is the design side; the slave modport is the bus/client side.
interface amba_lite_master_if;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_write;
    logic [31:0] i_cmd_addr;
    logic [31:0] i_cmd_wdata;

    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic [1:0]  o_rsp_err;

    logic        o_awvalid;
    logic        i_awready;
    logic [31:0] o_awaddr;

    logic        o_wvalid;
    logic        i_wready;
    logic [31:0] o_wdata;
    logic [3:0]  o_wstrb;

    logic        i_bvalid;
    logic        o_bready;
    logic [1:0]  i_bresp;

    logic        o_arvalid;
    logic        i_arready;
    logic [31:0] o_araddr;

    logic        i_rvalid;
    logic        o_rready;
    logic [31:0] i_rdata;
    logic [1:0]  i_rresp;

    modport master (
        input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_rsp_ready,
        input  i_awready, i_wready, i_bvalid, i_bresp, i_arready, i_rvalid, i_rdata, i_rresp,
        output o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        output o_awvalid, o_awaddr, o_wvalid, o_wdata, o_wstrb, o_bready,
        output o_arvalid, o_araddr, o_rready
    );

    modport slave (
        output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_rsp_ready,
        output i_awready, i_wready, i_bvalid, i_bresp, i_arready, i_rvalid, i_rdata, i_rresp,
        input  o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        input  o_awvalid, o_awaddr, o_wvalid, o_wdata, o_wstrb, o_bready,
        input  o_arvalid, o_araddr, o_rready
    );
endinterface

// File: rtl/amba_lite_master.sv
// Single-outstanding AXI-Lite-style bus master: one command in, one bus transaction
// out, one response back, with a per-handshake timeout that aborts a stuck bus.
module amba_lite_master #(
    parameter int TIMEOUT = 256
) (
    input  logic ACLK,
    input  logic ARST,
    amba_lite_master_if.master bus
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        aw_done;
    logic        w_done;

    logic        cmd_ready;
    logic        awvalid;
    logic        wvalid;
    logic        bready;
    logic        arvalid;
    logic        rready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;

    logic aw_hs, w_hs, cnt_hit;

    assign aw_hs   = awvalid && bus.i_awready;
    assign w_hs    = wvalid && bus.i_wready;
    // Reaching TIMEOUT means this is the last cycle a handshake may still win.
    assign cnt_hit = (cnt == CNT_LAST);

    function automatic logic [1:0] map_resp(input logic [1:0] r);
        return (r >= 2'b10) ? 2'b10 : 2'b00;
    endfunction

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            cmd_ready <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        addr_q    <= bus.i_cmd_addr;
                        wdata_q   <= bus.i_cmd_wdata;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        cnt       <= '0;
                        if (bus.i_cmd_write) begin
                            state   <= WR_REQ;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                        end else begin
                            state   <= RD_REQ;
                            arvalid <= 1'b1;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                WR_REQ: begin
                    if (aw_hs) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        state  <= WR_RESP;
                        bready <= 1'b1;
                        cnt    <= '0;
                    end else if (cnt_hit) begin
                        awvalid   <= 1'b0;
                        wvalid    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 2'b11;
                        state     <= RSP;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                WR_RESP: begin
                    if (bready && bus.i_bvalid) begin
                        bready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= map_resp(bus.i_bresp);
                        state     <= RSP;
                        cnt       <= '0;
                    end else if (cnt_hit) begin
                        bready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 2'b11;
                        state     <= RSP;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                RD_REQ: begin
                    if (arvalid && bus.i_arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_RESP;
                        cnt     <= '0;
                    end else if (cnt_hit) begin
                        arvalid   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 2'b11;
                        state     <= RSP;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                RD_RESP: begin
                    if (rready && bus.i_rvalid) begin
                        rready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= bus.i_rdata;
                        rsp_err   <= map_resp(bus.i_rresp);
                        state     <= RSP;
                        cnt       <= '0;
                    end else if (cnt_hit) begin
                        rready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 2'b11;
                        state     <= RSP;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                RSP: begin
                    if (bus.i_rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                        cnt       <= '0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    cmd_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_cmd_ready = cmd_ready;
    assign bus.o_rsp_valid = rsp_valid;
    assign bus.o_rsp_rdata = rsp_rdata;
    assign bus.o_rsp_err   = rsp_err;
    assign bus.o_awvalid   = awvalid;
    assign bus.o_awaddr    = addr_q;
    assign bus.o_wvalid    = wvalid;
    assign bus.o_wdata     = wdata_q;
    assign bus.o_wstrb     = 4'hF;
    assign bus.o_bready    = bready;
    assign bus.o_arvalid   = arvalid;
    assign bus.o_araddr    = addr_q;
    assign bus.o_rready    = rready;

endmodule

// File: tb/tb_amba_lite_master.sv
// Directed bench for amba_lite_master: stimulus pushes expected responses into a
// queue; a negedge monitor pops and compares on every response handshake.
module tb_amba_lite_master;

    logic ACLK = 1'b0;
    logic ARST = 1'b1;
    always #5 ACLK = ~ACLK;

    amba_lite_master_if bus();

    amba_lite_master #(.TIMEOUT(8)) dut (
        .ACLK (ACLK),
        .ARST (ARST),
        .bus  (bus)
    );

    logic [33:0] exp_q[$];   // {rdata, err}
    logic [33:0] mon_e;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #2;
    endtask

    always @(negedge ACLK) begin
        if (!ARST && bus.o_rsp_valid && bus.i_rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rdata 0x%0h err %0b, expected no response",
                         bus.o_rsp_rdata, bus.o_rsp_err);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_rdata", bus.o_rsp_rdata, mon_e[33:2]);
                chk("rsp_err", {30'd0, bus.o_rsp_err}, {30'd0, mon_e[1:0]});
            end
        end
    end

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
        chk("cmd_ready_before_issue", {31'd0, bus.o_cmd_ready}, 32'd1);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_write = wr;
        bus.i_cmd_addr  = a;
        bus.i_cmd_wdata = d;
        step();
        bus.i_cmd_valid = 1'b0;
        chk("cmd_ready_busy", {31'd0, bus.o_cmd_ready}, 32'd0);
    endtask

    task automatic finish_rsp(input string name);
        int n = 0;
        while (!bus.o_rsp_valid && n < 20) begin
            step();
            n++;
        end
        chk({name, "_rsp_valid"}, {31'd0, bus.o_rsp_valid}, 32'd1);
        bus.i_rsp_ready = 1'b1;
        step();
        bus.i_rsp_ready = 1'b0;
        chk({name, "_cmd_ready_after"}, {31'd0, bus.o_cmd_ready}, 32'd1);
        chk({name, "_rsp_valid_clear"}, {31'd0, bus.o_rsp_valid}, 32'd0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] rd, input logic [1:0] rr);
        issue(1'b0, a, 32'h0);
        chk("rd_araddr", bus.o_araddr, a);
        bus.i_arready = 1'b1;
        step();
        bus.i_arready = 1'b0;
        chk("rd_rready", {31'd0, bus.o_rready}, 32'd1);
        bus.i_rvalid = 1'b1;
        bus.i_rdata  = rd;
        bus.i_rresp  = rr;
        step();
        bus.i_rvalid = 1'b0;
        bus.i_rdata  = '0;
        bus.i_rresp  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected $finish");
        $fatal(1);
    end

    initial begin
        bus.i_cmd_valid = 0; bus.i_cmd_write = 0; bus.i_cmd_addr = 0; bus.i_cmd_wdata = 0;
        bus.i_rsp_ready = 0; bus.i_awready = 0; bus.i_wready = 0; bus.i_bvalid = 0;
        bus.i_bresp = 0; bus.i_arready = 0; bus.i_rvalid = 0; bus.i_rdata = 0; bus.i_rresp = 0;

        // reset held
        repeat (3) step();
        chk("rst_cmd_ready", {31'd0, bus.o_cmd_ready}, 32'd0);
        chk("rst_awvalid", {31'd0, bus.o_awvalid}, 32'd0);
        chk("rst_arvalid", {31'd0, bus.o_arvalid}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
        chk("rst_awaddr", bus.o_awaddr, 32'd0);
        ARST = 1'b0;
        step();
        chk("post_rst_cmd_ready", {31'd0, bus.o_cmd_ready}, 32'd1);

        // stray bvalid/rvalid in IDLE are ignored
        bus.i_bvalid = 1'b1; bus.i_rvalid = 1'b1;
        step();
        chk("idle_bready", {31'd0, bus.o_bready}, 32'd0);
        chk("idle_rready", {31'd0, bus.o_rready}, 32'd0);
        chk("idle_rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
        bus.i_bvalid = 1'b0; bus.i_rvalid = 1'b0;

        // write, AW and W accepted the same cycle
        exp_q.push_back({32'h0, 2'b00});
        issue(1'b1, 32'h2, 32'hDEADBEEF);
        chk("w1_awvalid", {31'd0, bus.o_awvalid}, 32'd1);
        chk("w1_wvalid", {31'd0, bus.o_wvalid}, 32'd1);
        chk("w1_awaddr", bus.o_awaddr, 32'h2);
        chk("w1_wdata", bus.o_wdata, 32'hDEADBEEF);
        chk("w1_wstrb", {28'd0, bus.o_wstrb}, 32'hF);
        chk("w1_bready_early", {31'd0, bus.o_bready}, 32'd0);
        bus.i_awready = 1'b1; bus.i_wready = 1'b1;
        step();
        bus.i_awready = 1'b0; bus.i_wready = 1'b0;
        chk("w1_awvalid_drop", {31'd0, bus.o_awvalid}, 32'd0);
        chk("w1_wvalid_drop", {31'd0, bus.o_wvalid}, 32'd0);
        chk("w1_bready", {31'd0, bus.o_bready}, 32'd1);
        bus.i_bvalid = 1'b1; bus.i_bresp = 2'b00;
        step();
        bus.i_bvalid = 1'b0;
        finish_rsp("w1");

        // write, W accepted three cycles before AW; bresp 01 maps to OKAY
        exp_q.push_back({32'h0, 2'b00});
        issue(1'b1, 32'h10, 32'hA5A50001);
        bus.i_wready = 1'b1;
        step();
        bus.i_wready = 1'b0;
        chk("w2_wvalid_drop", {31'd0, bus.o_wvalid}, 32'd0);
        chk("w2_awvalid_hold1", {31'd0, bus.o_awvalid}, 32'd1);
        step();
        chk("w2_awvalid_hold2", {31'd0, bus.o_awvalid}, 32'd1);
        chk("w2_bready_wait", {31'd0, bus.o_bready}, 32'd0);
        step();
        chk("w2_awvalid_hold3", {31'd0, bus.o_awvalid}, 32'd1);
        chk("w2_awaddr_stable", bus.o_awaddr, 32'h10);
        bus.i_awready = 1'b1;
        step();
        bus.i_awready = 1'b0;
        chk("w2_awvalid_drop", {31'd0, bus.o_awvalid}, 32'd0);
        chk("w2_bready", {31'd0, bus.o_bready}, 32'd1);
        bus.i_bvalid = 1'b1; bus.i_bresp = 2'b01;
        step();
        bus.i_bvalid = 1'b0; bus.i_bresp = 2'b00;
        finish_rsp("w2");

        // read, arready after two cycles, response held four cycles
        exp_q.push_back({32'h12345678, 2'b00});
        issue(1'b0, 32'h1, 32'h0);
        chk("r1_arvalid", {31'd0, bus.o_arvalid}, 32'd1);
        chk("r1_araddr", bus.o_araddr, 32'h1);
        step();
        chk("r1_arvalid_hold1", {31'd0, bus.o_arvalid}, 32'd1);
        step();
        chk("r1_arvalid_hold2", {31'd0, bus.o_arvalid}, 32'd1);
        chk("r1_rready_early", {31'd0, bus.o_rready}, 32'd0);
        bus.i_arready = 1'b1;
        step();
        bus.i_arready = 1'b0;
        chk("r1_arvalid_drop", {31'd0, bus.o_arvalid}, 32'd0);
        chk("r1_rready", {31'd0, bus.o_rready}, 32'd1);
        bus.i_rvalid = 1'b1; bus.i_rdata = 32'h12345678; bus.i_rresp = 2'b00;
        step();
        bus.i_rvalid = 1'b0; bus.i_rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            chk("r1_hold_valid", {31'd0, bus.o_rsp_valid}, 32'd1);
            chk("r1_hold_rdata", bus.o_rsp_rdata, 32'h12345678);
            chk("r1_hold_err", {30'd0, bus.o_rsp_err}, 32'd0);
            step();
        end
        finish_rsp("r1");

        // read timeout: arvalid high for exactly 8 cycles
        exp_q.push_back({32'h0, 2'b11});
        issue(1'b0, 32'h40, 32'h0);
        chk("to_arvalid_c0", {31'd0, bus.o_arvalid}, 32'd1);
        for (int i = 1; i < 8; i++) begin
            step();
            chk("to_arvalid_hold", {31'd0, bus.o_arvalid}, 32'd1);
        end
        step();
        chk("to_arvalid_drop", {31'd0, bus.o_arvalid}, 32'd0);
        chk("to_rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd1);
        finish_rsp("to");

        // write with SLVERR response
        exp_q.push_back({32'h0, 2'b10});
        issue(1'b1, 32'h20, 32'h11);
        bus.i_awready = 1'b1; bus.i_wready = 1'b1;
        step();
        bus.i_awready = 1'b0; bus.i_wready = 1'b0;
        step();
        chk("w3_bready_hold", {31'd0, bus.o_bready}, 32'd1);
        bus.i_bvalid = 1'b1; bus.i_bresp = 2'b10;
        step();
        bus.i_bvalid = 1'b0; bus.i_bresp = 2'b00;
        finish_rsp("w3");

        // write whose B channel never answers
        exp_q.push_back({32'h0, 2'b11});
        issue(1'b1, 32'h24, 32'h22);
        bus.i_awready = 1'b1; bus.i_wready = 1'b1;
        step();
        bus.i_awready = 1'b0; bus.i_wready = 1'b0;
        chk("w4_bready", {31'd0, bus.o_bready}, 32'd1);
        finish_rsp("w4");
        chk("w4_bready_drop", {31'd0, bus.o_bready}, 32'd0);

        // read with DECERR keeps the captured data
        exp_q.push_back({32'h0BAD0BAD, 2'b10});
        do_read(32'h30, 32'h0BAD0BAD, 2'b11);
        finish_rsp("r2");

        // reset in RD_RESP abandons the transaction
        issue(1'b0, 32'h8, 32'h0);
        bus.i_arready = 1'b1;
        step();
        bus.i_arready = 1'b0;
        chk("ar_rready", {31'd0, bus.o_rready}, 32'd1);
        ARST = 1'b1;
        step();
        chk("ar_rready_rst", {31'd0, bus.o_rready}, 32'd0);
        chk("ar_arvalid_rst", {31'd0, bus.o_arvalid}, 32'd0);
        chk("ar_rsp_valid_rst", {31'd0, bus.o_rsp_valid}, 32'd0);
        chk("ar_cmd_ready_rst", {31'd0, bus.o_cmd_ready}, 32'd0);
        ARST = 1'b0;
        step();
        chk("ar_cmd_ready_rel", {31'd0, bus.o_cmd_ready}, 32'd1);
        chk("ar_rsp_valid_rel", {31'd0, bus.o_rsp_valid}, 32'd0);
        exp_q.push_back({32'hCAFEF00D, 2'b00});
        do_read(32'h3C, 32'hCAFEF00D, 2'b00);
        finish_rsp("r3");

        repeat (3) step();
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/amba_lite_master.md
AMBA_LITE_MASTER -- requirements
Module: amba_lite_master

Interface
REQ-001 Parameter TIMEOUT, default 256: max cycles waited for any single bus handshake before aborting (range 2..65535).
REQ-002 ACLK  in  1  sole clock; all logic on posedge ACLK.
REQ-003 ARST  in  1  reset, synchronous, active-high.
REQ-004 i_cmd_valid  in  1 / o_cmd_ready  out  1: command handshake; transfer when both high.
REQ-005 i_cmd_write  in  1  1 = write, 0 = read; i_cmd_addr  in  32; i_cmd_wdata  in  32.
REQ-006 o_rsp_valid  out  1 / i_rsp_ready  in  1: response handshake; o_rsp_rdata  out  32; o_rsp_err  out  2 (00 OKAY, 10 SLVERR/DECERR from bus, 11 timeout).
REQ-007 Write address: o_awvalid out 1, i_awready in 1, o_awaddr out 32.
REQ-008 Write data: o_wvalid out 1, i_wready in 1, o_wdata out 32, o_wstrb out 4 (always 4'hF).
REQ-009 Write response: i_bvalid in 1, o_bready out 1, i_bresp in 2.
REQ-010 Read address: o_arvalid out 1, i_arready in 1, o_araddr out 32.
REQ-011 Read data: i_rvalid in 1, o_rready out 1, i_rdata in 32, i_rresp in 2.

Function
REQ-012 FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP; exactly one active.
REQ-013 o_cmd_ready high only in IDLE; command captured into internal addr/data/dir registers on handshake; no further command accepted until response handshake completes (one outstanding transaction).
REQ-014 IDLE -> WR_REQ (write) or RD_REQ (read) on command handshake; o_awvalid/o_wvalid or o_arvalid asserted the next cycle (1-cycle command-to-bus latency).
REQ-015 WR_REQ: o_awvalid and o_wvalid asserted together; each deasserts independently the cycle after its own ready is sampled high; AW and W may complete in either order or the same cycle.
REQ-016 WR_REQ -> WR_RESP once both AW and W complete; o_bready high only in WR_RESP; on i_bvalid sample i_bresp, -> RSP.
REQ-017 RD_REQ: o_arvalid held until i_arready, then -> RD_RESP; o_rready high only in RD_RESP; on i_rvalid capture i_rdata and i_rresp, -> RSP.
REQ-018 Valid outputs, once asserted, stay asserted with stable addr/data until ready (AMBA rule); never depend combinationally on ready.
REQ-019 o_awaddr/o_araddr/o_wdata driven from captured registers, stable for the whole transaction.
REQ-020 Response mapping: resp 00/01 -> o_rsp_err 00; 10/11 -> 10; o_rsp_rdata = captured i_rdata for reads, 0 for writes and on timeout.
REQ-021 RSP: o_rsp_valid high, fields stable until i_rsp_ready; handshake -> IDLE; o_cmd_ready high that next cycle.
REQ-022 Timeout counter, 16 bits, cleared on every state entry, increments each cycle in WR_REQ, WR_RESP, RD_REQ, RD_RESP; reaching TIMEOUT forces all bus valid/ready low, o_rsp_err = 11, -> RSP.
REQ-023 Bus handshake completing in the same cycle the counter reaches TIMEOUT takes priority over timeout.
REQ-024 i_bvalid/i_rvalid arriving outside WR_RESP/RD_RESP ignored (ready low).

Reset
REQ-025 ARST high at a clock edge: state IDLE, counter 0, captured registers 0; all outputs 0 except o_cmd_ready = 1 the cycle after ARST releases; held while ARST high.
REQ-026 ARST mid-transaction abandons it immediately; no response emitted for it.

Verification
REQ-027 Write addr 0x2, data 0xDEADBEEF, awready+wready high same cycle, bvalid 1 cycle later bresp 00 -> AW/W valid for exactly 1 cycle, rsp_valid with err 00, rdata 0.
REQ-028 Write with wready 3 cycles before awready -> o_wvalid drops after its handshake, o_awvalid held until awready, single response err 00.
REQ-029 Read addr 0x1, arready after 2 cycles, rvalid with rdata 0x12345678 rresp 00 -> o_rsp_rdata 0x12345678, err 00; rsp held 4 cycles with i_rsp_ready low, fields stable.
REQ-030 TIMEOUT=8, read with arready never high -> o_arvalid drops after 8 cycles, o_rsp_err 11, rdata 0; next command accepted normally.
REQ-031 Write with bresp 10 -> o_rsp_err 10.
REQ-032 ARST asserted in RD_RESP -> all valids low next cycle, no rsp_valid, o_cmd_ready 1 after release; new read completes correctly.
